// File: rtl/sdram_cmd_fifo.sv
// Purpose: command FIFO between the request source and the SDRAM controller. The head entry appears at the output without a read cycle.
// Latency: a push into an empty FIFO shows up on m_valid_o/m_cmd_o one cycle later. No command passes straight from input to output in the same cycle.
// Backpressure: s_ready_o comes only from the registered occupancy, so a pop does not free a full FIFO until the next cycle.

package sdram_cmd_pkg;
  typedef struct packed {
    logic        rw;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        auto_precharge_en;
  } sdram_cmd_t;
endpackage

module sdram_cmd_fifo
  import sdram_cmd_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  sdram_cmd_t             s_cmd_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output sdram_cmd_t             m_cmd_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   almost_full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Data storage is left unreset so it maps onto plain registers or RAM.
  sdram_cmd_t    mem [DEPTH];

  // Handshakes and flags all come from the registered count. Neither
  // s_valid_i nor m_ready_i has a combinational path to any ready, valid or flag output.
  assign s_ready_o     = (count != CW'(DEPTH));
  assign m_valid_o     = (count != '0);
  assign empty_o       = (count == '0);
  assign almost_full_o = (count >= CW'(AFULL_LEVEL));
  assign count_o       = count;
  assign push          = s_valid_i && s_ready_o;
  assign pop           = m_valid_o && m_ready_i;

  // First-word fall-through: the output always shows the entry at the read pointer.
  assign m_cmd_o = mem[rd_ptr];

  // Update the pointers and the occupancy. Flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write the accepted command. A command offered during a flush is dropped.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= s_cmd_i;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_fifo.sv
// Purpose: exercise sdram_cmd_fifo with directed scenarios and random traffic, checking it against a queue model.
// Latency: outputs are sampled 1 time unit after each rising edge, or between edges while reset is asserted asynchronously.
// Backpressure: the model accepts a push only while it holds fewer than DEPTH entries, and pops only while it holds at least one.

module tb_sdram_cmd_fifo;
  import sdram_cmd_pkg::*;

  localparam int DEPTH       = 8;
  localparam int AFULL_LEVEL = 6;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       flush_i;
  logic       s_valid_i;
  logic       s_ready_o;
  sdram_cmd_t s_cmd_i;
  logic       m_valid_o;
  logic       m_ready_i;
  sdram_cmd_t m_cmd_o;
  logic [$clog2(DEPTH):0] count_o;
  logic       almost_full_o;
  logic       empty_o;

  int checks = 0;
  int errors = 0;

  sdram_cmd_t model_q[$];

  sdram_cmd_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL_LEVEL)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_cmd_i(s_cmd_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_cmd_o(m_cmd_o),
    .count_o(count_o), .almost_full_o(almost_full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic sdram_cmd_t mk_cmd(bit rw, logic [23:0] a, logic [15:0] d, bit ap);
    sdram_cmd_t c;
    c.rw = rw; c.addr = a; c.wdata = d; c.auto_precharge_en = ap;
    return c;
  endfunction

  function automatic sdram_cmd_t rand_cmd();
    return mk_cmd(1'($urandom), 24'($urandom), 16'($urandom), 1'($urandom));
  endfunction

  task automatic set_in(bit v, sdram_cmd_t c, bit r, bit f);
    s_valid_i = v; s_cmd_i = c; m_ready_i = r; flush_i = f;
  endtask

  // Apply one rising edge to the model using the inputs driven now, then step the DUT clock.
  task automatic tick();
    bit do_push, do_pop;
    if (!rstn_i || flush_i) begin
      model_q.delete();
    end else begin
      do_push = s_valid_i && (model_q.size() < DEPTH);
      do_pop  = m_ready_i && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(s_cmd_i);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    set_in(0, '0, 0, 0);
    #2;
    checks++; if (int'(count_o) !== 0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid_o); end
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
    checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b expected 0", almost_full_o); end
    tick();
    tick();
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_empty_to_one();
    sdram_cmd_t c;
    c = mk_cmd(1'b0, 24'h000100, 16'h0000, 1'b0);
    set_in(1, c, 0, 0);
    #1;
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL e2o_no_bypass: got %b expected 0", m_valid_o); end
    tick();
    set_in(0, '0, 0, 0);
    checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL e2o_m_valid: got %b expected 1", m_valid_o); end
    checks++; if (m_cmd_o !== c) begin errors++; $display("FAIL e2o_cmd: got %h expected %h", m_cmd_o, c); end
    checks++; if (int'(count_o) !== 1) begin errors++; $display("FAIL e2o_count: got %0d expected 1", count_o); end
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL e2o_empty: got %b expected 0", empty_o); end
    set_in(0, '0, 1, 0);
    tick();
    set_in(0, '0, 0, 0);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL e2o_drain: got %b expected 1", empty_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      set_in(1, mk_cmd(1'b1, 24'(i), 16'($urandom), 1'b0), 0, 0);
      tick();
      checks++; if (int'(count_o) !== i + 1) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count_o, i + 1); end
      checks++; if (almost_full_o !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full_o, (i + 1 >= 6)); end
      checks++; if (s_ready_o !== (i + 1 != 8)) begin errors++; $display("FAIL fill_s_ready[%0d]: got %b expected %b", i, s_ready_o, (i + 1 != 8)); end
    end
    set_in(1, mk_cmd(1'b1, 24'd99, 16'h0, 1'b0), 0, 0);
    tick();
    checks++; if (int'(count_o) !== 8) begin errors++; $display("FAIL fill_ninth_count: got %0d expected 8", count_o); end
    checks++; if (m_cmd_o.addr !== 24'd0) begin errors++; $display("FAIL fill_ninth_head: got %h expected 0", m_cmd_o.addr); end
  endtask

  task automatic test_full_pop();
    sdram_cmd_t held;
    held = mk_cmd(1'b1, 24'd8, 16'hBEEF, 1'b1);
    set_in(1, held, 1, 0);
    #1;
    checks++; if (m_cmd_o.addr !== 24'd0) begin errors++; $display("FAIL fullpop_popped: got %h expected 0", m_cmd_o.addr); end
    tick();
    checks++; if (int'(count_o) !== 7) begin errors++; $display("FAIL fullpop_count: got %0d expected 7", count_o); end
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL fullpop_s_ready: got %b expected 1", s_ready_o); end
    set_in(1, held, 0, 0);
    tick();
    set_in(0, '0, 1, 0);
    checks++; if (int'(count_o) !== 8) begin errors++; $display("FAIL fullpop_refill: got %0d expected 8", count_o); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (m_cmd_o.addr !== 24'(i)) begin errors++; $display("FAIL fullpop_order[%0d]: got %h expected %h", i, m_cmd_o.addr, 24'(i)); end
      tick();
    end
    checks++; if (m_cmd_o === held && m_valid_o) begin errors++; $display("FAIL fullpop_dup: got valid held cmd expected empty"); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fullpop_empty: got %b expected 1", empty_o); end
    set_in(0, '0, 0, 0);
  endtask

  task automatic test_stream_wrap();
    logic [23:0] base;
    base = 24'h0A0000;
    for (int k = 0; k < 20; k++) begin
      set_in(1, mk_cmd(1'b0, base + 24'(k), 16'(k), 1'b0), 1, 0);
      tick();
      checks++; if (int'(count_o) !== 1) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 1", k, count_o); end
      checks++; if (m_cmd_o.addr !== base + 24'(k)) begin errors++; $display("FAIL stream_head[%0d]: got %h expected %h", k, m_cmd_o.addr, base + 24'(k)); end
    end
    set_in(0, '0, 1, 0);
    tick();
    set_in(0, '0, 0, 0);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_flush();
    sdram_cmd_t fresh;
    for (int i = 0; i < 5; i++) begin
      set_in(1, rand_cmd(), 0, 0);
      tick();
    end
    checks++; if (int'(count_o) !== 5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count_o); end
    set_in(1, mk_cmd(1'b1, 24'hDEAD00, 16'h1234, 1'b1), 1, 1);
    tick();
    set_in(0, '0, 0, 0);
    checks++; if (int'(count_o) !== 0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL flush_m_valid: got %b expected 0", m_valid_o); end
    fresh = mk_cmd(1'b0, 24'h00F00D, 16'h5A5A, 1'b0);
    set_in(1, fresh, 0, 0);
    tick();
    set_in(0, '0, 1, 0);
    checks++; if (m_cmd_o !== fresh || int'(count_o) !== 1) begin errors++; $display("FAIL flush_after: got %h cnt %0d expected %h cnt 1", m_cmd_o, count_o, fresh); end
    tick();
    set_in(0, '0, 0, 0);
  endtask

  task automatic test_async_reset();
    sdram_cmd_t first;
    for (int i = 0; i < 3; i++) begin
      set_in(1, rand_cmd(), 0, 0);
      tick();
    end
    set_in(0, '0, 0, 0);
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    checks++; if (int'(count_o) !== 0 || m_valid_o !== 1'b0 || s_ready_o !== 1'b1 || empty_o !== 1'b1 || almost_full_o !== 1'b0) begin
      errors++; $display("FAIL arst_async: got cnt %0d mv %b sr %b em %b af %b expected 0 0 1 1 0", count_o, m_valid_o, s_ready_o, empty_o, almost_full_o);
    end
    tick();
    @(negedge clk_i);
    rstn_i = 1'b1;
    first = mk_cmd(1'b1, 24'h123456, 16'hCAFE, 1'b1);
    set_in(1, first, 0, 0);
    tick();
    set_in(0, '0, 0, 0);
    checks++; if (m_valid_o !== 1'b1 || m_cmd_o !== first) begin errors++; $display("FAIL arst_first_push: got mv %b %h expected 1 %h", m_valid_o, m_cmd_o, first); end
    checks++; if (int'(count_o) !== 1) begin errors++; $display("FAIL arst_count: got %0d expected 1", count_o); end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 400; i++) begin
      n = model_q.size();
      set_in(($urandom_range(99) < 70), rand_cmd(),
             ($urandom_range(99) < ((i < 200) ? 35 : 65)),
             ($urandom_range(99) < 3));
      tick();
      n = model_q.size();
      checks++; if (int'(count_o) !== n) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count_o, n); end
      checks++; if (m_valid_o !== (n != 0) || empty_o !== (n == 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got mv %b em %b expected n=%0d", i, m_valid_o, empty_o, n); end
      checks++; if (s_ready_o !== (n != DEPTH) || almost_full_o !== (n >= AFULL_LEVEL)) begin errors++; $display("FAIL rnd_flags[%0d]: got sr %b af %b expected n=%0d", i, s_ready_o, almost_full_o, n); end
      if (n != 0) begin
        checks++; if (m_cmd_o !== model_q[0]) begin errors++; $display("FAIL rnd_head[%0d]: got %h expected %h", i, m_cmd_o, model_q[0]); end
      end
    end
    set_in(0, '0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_empty_to_one();
    test_fill();
    test_full_pop();
    test_stream_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
